truth_table_sequencer: RTL
==========================

Name: truth_table_sequencer

Overview:
- Sequencing controller for an evolved 4-input/4-output gate-level candidate circuit used in fitness evaluation.
- Steps the candidate's input vector through all 2^N_IN combinations and waits a programmable settle time for gate delays to propagate.
- Samples the candidate outputs and compares them against a target truth table under a per-output mask.
- Accumulates a fitness score (matching bits) and a per-row mismatch vector, then pulses done.

Parameters:
- N_IN, 4, number of candidate inputs; ROWS = 2^N_IN.
- N_OUT, 4, number of candidate outputs.
- SETTLE_CYCLES, 4, clock cycles each row is held before sampling; legal range 1..255.
- SW, 7, score width; must be at least clog2(ROWS*N_OUT+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- target_table  in  ROWS*N_OUT  expected outputs; row r occupies bits [r*N_OUT +: N_OUT].
- out_mask  in  N_OUT  1 = output bit is scored; 0 = ignored.
- dut_in  out  N_IN  registered input vector driven to the candidate circuit.
- dut_out  in  N_OUT  candidate outputs; sampled only in SAMPLE.
- busy  out  1  high in SETTLE, SAMPLE and DONE.
- done  out  1  one-cycle pulse when evaluation completes.
- score_valid  out  1  score and mismatch_vec hold a complete result.
- score  out  SW  count of masked output bits matching target, 0..ROWS*N_OUT.
- mismatch_vec  out  ROWS  bit r = 1 if row r had any masked mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; dut_in, score, mismatch_vec, busy, done, score_valid all 0.
  - Effective immediately, including mid-evaluation.
- States: IDLE, SETTLE, SAMPLE, DONE. dut_in is the row register.
- IDLE:
  - start=1 at an edge → row=0, cnt=SETTLE_CYCLES, score=0, mismatch_vec=0, score_valid=0, state=SETTLE.
  - Otherwise hold; previous results remain visible.
- SETTLE:
  - cnt==1 → SAMPLE; else cnt-1.
  - The row is held exactly SETTLE_CYCLES cycles before sampling.
- SAMPLE (one cycle):
  - m = ~(dut_out ^ target_table[row]) & out_mask.
  - score += popcount(m).
  - mismatch_vec[row] = |((dut_out ^ target_table[row]) & out_mask).
  - row==ROWS-1 → DONE; else row+1, cnt=SETTLE_CYCLES, state=SETTLE.
- DONE (one cycle):
  - done=1, score_valid=1 (held until next start, abort or reset).
  - Next edge: row=0, state=IDLE.
- Latency: start accepted at edge 0 → done high during the cycle after edge ROWS*(SETTLE_CYCLES+1). Defaults give edge 80; done deasserts at edge 81.
- abort in SETTLE/SAMPLE/DONE:
  - Next edge: IDLE, row=0, done not pulsed (DONE-cycle pulse completes but score_valid is cleared).
  - Partial score and mismatch_vec are retained; score_valid=0.
  - abort has priority over start; abort in IDLE is ignored.
- start while busy: ignored.
- target_table and out_mask are sampled live in each SAMPLE and must be held stable while busy.
- out_mask=0: score=0, mismatch_vec=0 at done.
- Score never wraps: SW is sized for ROWS*N_OUT.
- dut_out is treated as asynchronous-to-logic combinational settling; no synchronizer. The settle time alone guarantees validity.

Test Plan:
1. Identity candidate (dut_out=dut_in, zero delay), target row r = r, mask=4'hF, SETTLE_CYCLES=4, start pulse → done during cycle after edge 80, score=64, mismatch_vec=16'h0000, score_valid=1.
2. Identity candidate, target all zeros, mask=4'hF → score=32, mismatch_vec=16'hFFFE.
3. Identity candidate, target all zeros, mask=4'b0001 → score=8, mismatch_vec=16'hAAAA; mask=4'h0 → score=0, mismatch_vec=0.
4. Bench delays dut_out by 3 cycles after each dut_in change, target row r = r:
   - SETTLE_CYCLES=4 → score=64.
   - SETTLE_CYCLES=2 → score<64 and mismatch_vec[1]=1.
5. Abort asserted during row 5 SETTLE → next edge busy=0, dut_in=0, no done pulse, score_valid=0. start held high while busy in a fresh run is ignored; run still completes at edge 80.
6. rst_n driven low asynchronously mid row 9 → dut_in, busy, score, mismatch_vec, score_valid drop to 0 before the next clock edge. After release, IDLE holds until start.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks a candidate circuit through every input row,
// waits for settling, samples its outputs and scores them against a target.
// Ports: clk, rst_n, start, abort, target_table, out_mask, dut_out (in);
//        dut_in, busy, done, score_valid, score, mismatch_vec (out).
module truth_table_sequencer #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SW            = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [(1<<N_IN)*N_OUT-1:0] target_table,
  input  logic [N_OUT-1:0]           out_mask,
  output logic [N_IN-1:0]            dut_in,
  input  logic [N_OUT-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       score_valid,
  output logic [SW-1:0]              score,
  output logic [(1<<N_IN)-1:0]       mismatch_vec
);

  localparam int ROWS = 1 << N_IN;
  localparam logic [7:0] SC = 8'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, SAMPLE, DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  logic [N_OUT-1:0] tgt;
  logic [N_OUT-1:0] diff;
  logic [N_OUT-1:0] hits;
  logic [SW-1:0]    hit_cnt;

  always_comb begin
    tgt     = target_table[dut_in*N_OUT +: N_OUT];
    diff    = (dut_out ^ tgt) & out_mask;
    hits    = ~(dut_out ^ tgt) & out_mask;
    hit_cnt = '0;
    for (int i = 0; i < N_OUT; i++)
      hit_cnt = hit_cnt + SW'(hits[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      score_valid  <= 1'b0;
      score        <= '0;
      mismatch_vec <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dut_in       <= '0;
            cnt          <= SC;
            score        <= '0;
            mismatch_vec <= '0;
            score_valid  <= 1'b0;
            busy         <= 1'b1;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            dut_in <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cnt == 8'd1) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            dut_in <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            score                <= score + hit_cnt;
            mismatch_vec[dut_in] <= |diff;
            if (dut_in == LAST) begin
              done        <= 1'b1;
              score_valid <= 1'b1;
              state       <= DONE;
            end else begin
              dut_in <= dut_in + 1'b1;
              cnt    <= SC;
              state  <= SETTLE;
            end
          end
        end
        DONE: begin
          // the done pulse already ran its cycle; abort only voids the result
          if (abort) score_valid <= 1'b0;
          dut_in <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
